// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: 1 ms tick prescaler, start/stop/lap FSM, BCD digit cascade and lap latch.
// Optional macro COUNT_WRAP_EN: wrap 9.999 -> 0.000 with sticky overflow instead of saturating in DONE.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 50000,
   parameter int PRESC_W  = 16
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       start_stop,
   input  logic       lap_reset,
   output logic       tick_en,
   output logic       running,
   output logic       overflow,
   output logic [3:0] seconds,
   output logic [3:0] tenths,
   output logic [3:0] hundreths,
   output logic [3:0] thousandths
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_LAP  = 3'd2,
      S_STOP = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [PRESC_W-1:0] LP_TOP = PRESC_W'(TICK_DIV - 1);
`ifdef COUNT_WRAP_EN
   localparam logic LP_WRAP = 1'b1;
`else
   localparam logic LP_WRAP = 1'b0;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PRESC_W-1:0]  r_presc;
   logic [15:0]         r_live;
   logic [15:0]         r_lap;
   logic                r_ovf;
   logic [15:0]         w_live_inc;
   logic                w_tick;
   logic                w_term;
   logic                w_sat;
   logic                w_capture;
   logic                w_clear_all;
   logic                w_presc_zero;

   // Four-digit BCD increment; a digit at 9 rolls to 0 and passes the carry upward.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   assign running    = (r_state == S_RUN) || (r_state == S_LAP);
   assign w_tick     = running && (r_presc == LP_TOP);
   assign w_term     = w_tick && (r_live == 16'h9999);
   assign w_sat      = w_term && !LP_WRAP;
   assign w_live_inc = bcd_inc(r_live);

   // Terminal count outranks the buttons; start_stop outranks lap_reset.
   always_comb begin
      w_state_nxt  = r_state;
      w_capture    = 1'b0;
      w_clear_all  = 1'b0;
      w_presc_zero = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_stop) begin
               w_state_nxt  = S_RUN;
               w_presc_zero = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_sat) begin
               w_state_nxt = S_DONE;
            end else if (start_stop) begin
               w_state_nxt = S_STOP;
            end else if (lap_reset) begin
               w_state_nxt = S_LAP;
               w_capture   = 1'b1;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_LAP: begin
            if (w_sat) begin
               w_state_nxt = S_DONE;
            end else if (start_stop) begin
               w_state_nxt = S_STOP;
            end else if (lap_reset) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_LAP;
            end
         end
         S_STOP: begin
            if (start_stop) begin
               w_state_nxt = S_RUN;
            end else if (lap_reset) begin
               w_state_nxt = S_IDLE;
               w_clear_all = 1'b1;
            end else begin
               w_state_nxt = S_STOP;
            end
         end
         S_DONE: begin
            if (lap_reset) begin
               w_state_nxt = S_IDLE;
               w_clear_all = 1'b1;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Prescaler, live digits, lap latch and overflow flag.
   always_ff @(posedge clk) begin
      if (clear) begin
         r_presc <= '0;
         r_live  <= 16'h0000;
         r_lap   <= 16'h0000;
         r_ovf   <= 1'b0;
      end else begin
         if (w_clear_all || w_presc_zero || w_tick) begin
            r_presc <= '0;
         end else if (running) begin
            r_presc <= r_presc + PRESC_W'(1);
         end else begin
            r_presc <= r_presc;
         end

         if (w_clear_all) begin
            r_live <= 16'h0000;
         end else if (w_tick && !w_sat) begin
            r_live <= w_live_inc;
         end else begin
            r_live <= r_live;
         end

         if (w_clear_all) begin
            r_lap <= 16'h0000;
         end else if (w_capture) begin
            r_lap <= r_live;
         end else begin
            r_lap <= r_lap;
         end

         if (w_clear_all) begin
            r_ovf <= 1'b0;
         end else if (w_term) begin
            r_ovf <= 1'b1;
         end else begin
            r_ovf <= r_ovf;
         end
      end
   end

   assign tick_en  = w_tick;
   assign overflow = r_ovf;
   assign {seconds, tenths, hundreths, thousandths} = (r_state == S_LAP) ? r_lap : r_live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl (TICK_DIV=4): directed scenarios plus random button traffic
// compared every cycle against an integer-count reference model.
module tb_stopwatch_ctrl;

   localparam int TD = 4;
   localparam int MI = 0, MR = 1, ML = 2, MS = 3, MD = 4;
`ifdef COUNT_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       start_stop = 1'b0;
   logic       lap_reset = 1'b0;
   logic       tick_en, running, overflow;
   logic [3:0] seconds, tenths, hundreths, thousandths;

   int n_checks = 0;
   int n_errors = 0;
   int max_dig  = 0;

   // Reference model: count as a plain integer 0..9999, phase as a cycle counter.
   int m_mode, m_count, m_lap, m_phase;
   bit m_ovf;

   stopwatch_ctrl #(.TICK_DIV(TD), .PRESC_W(3)) dut (
      .clk(clk), .clear(clear), .start_stop(start_stop), .lap_reset(lap_reset),
      .tick_en(tick_en), .running(running), .overflow(overflow),
      .seconds(seconds), .tenths(tenths), .hundreths(hundreths), .thousandths(thousandths)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [18:0] model_outs();
      bit run, tick;
      run  = (m_mode == MR) || (m_mode == ML);
      tick = run && (m_phase == TD - 1);
      return {tick, run, m_ovf, to_bcd((m_mode == ML) ? m_lap : m_count)};
   endfunction

   task automatic model_reset();
      m_mode = MI; m_count = 0; m_lap = 0; m_phase = 0; m_ovf = 1'b0;
   endtask

   task automatic model_step(input bit ss, input bit lr, input bit clr);
      bit run, tick, term;
      int n_mode, n_count, n_lap, n_phase;
      bit n_ovf;
      if (clr) begin
         model_reset();
         return;
      end
      run  = (m_mode == MR) || (m_mode == ML);
      tick = run && (m_phase == TD - 1);
      term = tick && (m_count == 9999);
      n_mode = m_mode; n_count = m_count; n_lap = m_lap; n_phase = m_phase; n_ovf = m_ovf;
      if (tick) begin
         n_phase = 0;
         if (m_count == 9999) n_count = WRAP ? 0 : 9999;
         else n_count = m_count + 1;
      end else if (run) begin
         n_phase = m_phase + 1;
      end
      if (term) n_ovf = 1'b1;
      if (term && !WRAP) begin
         n_mode = MD;
      end else if (ss) begin
         if (m_mode == MI) begin
            n_mode = MR; n_phase = 0;
         end else if (m_mode == MR || m_mode == ML) begin
            n_mode = MS;
         end else if (m_mode == MS) begin
            n_mode = MR;
         end
      end else if (lr) begin
         if (m_mode == MR) begin
            n_mode = ML; n_lap = m_count;
         end else if (m_mode == ML) begin
            n_mode = MR;
         end else if (m_mode == MS || m_mode == MD) begin
            n_mode = MI; n_count = 0; n_lap = 0; n_phase = 0; n_ovf = 1'b0;
         end
      end
      m_mode = n_mode; m_count = n_count; m_lap = n_lap; m_phase = n_phase; m_ovf = n_ovf;
   endtask

   function automatic logic [15:0] disp();
      return {seconds, tenths, hundreths, thousandths};
   endfunction

   // One clock: compare against the model, apply inputs across the rising edge, advance the model.
   task automatic step(input bit ss, input bit lr, input bit clr);
      logic [15:0] d;
      check("outs", 32'({tick_en, running, overflow, disp()}), 32'(model_outs()));
      d = disp();
      for (int i = 0; i < 4; i++) begin
         if (int'(d[4*i +: 4]) > max_dig) max_dig = int'(d[4*i +: 4]);
      end
      start_stop = ss; lap_reset = lr; clear = clr;
      @(posedge clk);
      model_step(ss, lr, clr);
      @(negedge clk);
      start_stop = 1'b0; lap_reset = 1'b0; clear = 1'b0;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int tcnt, prev, k;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;

      // Reset mid-count with buttons asserted.
      step(1'b1, 1'b0, 1'b0);
      run_n(10);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check("rst_disp", 32'(disp()), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_tick", 32'(tick_en), 32'h0);

      // Basic count: 48 clocks give 12 ticks, 4 clocks apart.
      step(1'b1, 1'b0, 1'b0);
      tcnt = 0; prev = -1;
      for (int c = 1; c <= 48; c++) begin
         if (tick_en) begin
            tcnt++;
            if (prev >= 0) check("tick_gap", 32'(c - prev), 32'd4);
            prev = c;
         end
         step(1'b0, 1'b0, 1'b0);
      end
      check("basic_disp", 32'(disp()), 32'h0012);
      check("basic_running", 32'(running), 32'h1);
      check("basic_ticks", 32'(tcnt), 32'd12);

      // Cascade across 0.099 and 0.999.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_n(396);
      check("casc_099", 32'(disp()), 32'h0099);
      run_n(4);
      check("casc_100", 32'(disp()), 32'h0100);
      run_n(3596);
      check("casc_999", 32'(disp()), 32'h0999);
      run_n(4);
      check("casc_1000", 32'(disp()), 32'h1000);

      // Lap freeze and release.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_n(20);
      step(1'b0, 1'b1, 1'b0);
      check("lap_freeze", 32'(disp()), 32'h0005);
      tcnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (tick_en) tcnt++;
         step(1'b0, 1'b0, 1'b0);
      end
      check("lap_hold", 32'(disp()), 32'h0005);
      check("lap_ticks", 32'(tcnt), 32'd10);
      step(1'b0, 1'b1, 1'b0);
      check("lap_release", 32'(disp()), 32'h0015);

      // Stop, resume with preserved phase, stop and clear.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_n(28);
      step(1'b1, 1'b0, 1'b0);
      run_n(20);
      check("stop_hold", 32'(disp()), 32'h0007);
      check("stop_running", 32'(running), 32'h0);
      step(1'b1, 1'b0, 1'b0);
      k = 0;
      while (disp() == 16'h0007 && k < 10) begin
         step(1'b0, 1'b0, 1'b0);
         k++;
      end
      check("resume_latency", 32'(k), 32'd3);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("stop_clear_disp", 32'(disp()), 32'h0);
      check("stop_clear_run", 32'(running), 32'h0);
      step(1'b0, 1'b1, 1'b0);
      check("idle_lr_ignored", 32'(running), 32'h0);
      step(1'b1, 1'b0, 1'b0);
      run_n(4);
      check("restart_first", 32'(disp()), 32'h0001);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("both_to_stop", 32'(running), 32'h0);
      step(1'b0, 1'b1, 1'b0);
      check("both_then_clear", 32'(disp()), 32'h0);

      // Random button traffic against the model.
      step(1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
      end

      // Terminal count.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      run_n(39996);
      check("term_9999", 32'(disp()), 32'h9999);
      check("term_ovf_pre", 32'(overflow), 32'h0);
      run_n(4);
`ifdef COUNT_WRAP_EN
      check("wrap_disp", 32'(disp()), 32'h0);
      check("wrap_ovf", 32'(overflow), 32'h1);
      check("wrap_running", 32'(running), 32'h1);
      step(1'b1, 1'b0, 1'b0);
      run_n(3);
      check("wrap_ovf_sticky", 32'(overflow), 32'h1);
      step(1'b0, 1'b1, 1'b0);
      check("wrap_clear_disp", 32'(disp()), 32'h0);
      check("wrap_clear_ovf", 32'(overflow), 32'h0);
`else
      check("sat_disp", 32'(disp()), 32'h9999);
      check("sat_ovf", 32'(overflow), 32'h1);
      check("sat_running", 32'(running), 32'h0);
      step(1'b1, 1'b0, 1'b0);
      run_n(8);
      check("done_ss_ignored", 32'(running), 32'h0);
      check("done_hold", 32'(disp()), 32'h9999);
      step(1'b0, 1'b1, 1'b0);
      check("done_clear_disp", 32'(disp()), 32'h0);
      check("done_clear_ovf", 32'(overflow), 32'h0);
`endif
      step(1'b0, 1'b0, 1'b0);
      check("max_digit", 32'(max_dig), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
